// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//
// Pointer/control stage that sits directly upstream of the FIFO status-flag
// block. It gates raw producer/consumer requests into memory strobes, owns the
// wrap-bit-extended write/read pointers that the status block compares, and
// adds occupancy tracking, threshold flags, sticky error flags and a
// registered read-valid.
//
// Parameters
//   ADDR_WIDTH  memory address width, depth = 2**ADDR_WIDTH
//   AF_LEVEL    almost_full when fifo_count >= AF_LEVEL  (1 .. depth)
//   AE_LEVEL    almost_empty when fifo_count <= AE_LEVEL (0 .. depth-1)
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   wr_en, rd_en  raw write/read requests
//   clr_flags     clears the sticky overflow/underflow flags
//   fifo_full     status-block flag (combinational on wptr/rptr)
//   fifo_empty    status-block flag (combinational on wptr/rptr)
//   wptr, rptr    registered pointers, MSB is the wrap bit
//   wr_addr       memory write address (low bits of wptr)
//   rd_addr       memory read address  (low bits of rptr)
//   mem_we        gated write strobe (combinational)
//   mem_re        gated read strobe  (combinational)
//   rd_valid      mem_re delayed one cycle: memory read data is valid
//   fifo_count    registered occupancy, 0 .. depth
//   almost_full   registered threshold flag
//   almost_empty  registered threshold flag
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_flags,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [PW-1:0] count_reg;
    logic [PW-1:0] count_next;
    logic          rd_valid_reg;
    logic          almost_full_reg;
    logic          almost_empty_reg;
    logic          overflow_reg;
    logic          underflow_reg;

    // Gating looks only at the flags of the current pointers; a read in the
    // same cycle does not make room for a write when full (and vice versa).
    assign mem_we = wr_en & ~fifo_full;
    assign mem_re = rd_en & ~fifo_empty;

    // Gated strobes guarantee count stays inside 0..depth without clamping.
    always_comb begin
        count_next = count_reg
                   + {{ADDR_WIDTH{1'b0}}, mem_we}
                   - {{ADDR_WIDTH{1'b0}}, mem_re};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            count_reg        <= '0;
            rd_valid_reg     <= 1'b0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            // Natural modulo-2**PW wrap: the MSB toggles on every pass.
            if (mem_we) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (mem_re) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end

            count_reg    <= count_next;
            rd_valid_reg <= mem_re;

            // Thresholds come from the next-state count so they line up
            // with fifo_count in the same cycle.
            almost_full_reg  <= (count_next >= AF_THRESH);
            almost_empty_reg <= (count_next <= AE_THRESH);

            // A new error event wins over a simultaneous clear.
            if (wr_en & fifo_full) begin
                overflow_reg <= 1'b1;
            end else if (clr_flags) begin
                overflow_reg <= 1'b0;
            end

            if (rd_en & fifo_empty) begin
                underflow_reg <= 1'b1;
            end else if (clr_flags) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign wptr         = wptr_reg;
    assign rptr         = rptr_reg;
    assign fifo_count   = count_reg;
    assign rd_valid     = rd_valid_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Memory addresses are the pointers without their wrap bit.
    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr
            assign wr_addr[gi] = wptr_reg[gi];
            assign rd_addr[gi] = rptr_reg[gi];
        end
    endgenerate

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
- Pointer/control stage directly upstream of the FIFO status-flag block.
- Converts raw write/read requests into gated memory strobes.
- Maintains the (ADDR_WIDTH+1)-bit write and read pointers that the status block compares.
- Consumes that block's fifo_full/fifo_empty flags, and adds an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read-valid.

Parameters:
- ADDR_WIDTH, 3: memory address width. Depth = 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- AF_LEVEL, 6: almost_full asserts when fifo_count >= AF_LEVEL. Must satisfy 1 <= AF_LEVEL <= 2^ADDR_WIDTH.
- AE_LEVEL, 2: almost_empty asserts when fifo_count <= AE_LEVEL. Must satisfy 0 <= AE_LEVEL < 2^ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request from producer.
- rd_en  input  1  read request from consumer.
- clr_flags  input  1  synchronous clear of the overflow/underflow sticky flags.
- fifo_full  input  1  from the status block; combinational function of wptr/rptr.
- fifo_empty  input  1  from the status block; combinational function of wptr/rptr.
- wptr  output  ADDR_WIDTH+1  write pointer, registered.
- rptr  output  ADDR_WIDTH+1  read pointer, registered.
- wr_addr  output  ADDR_WIDTH  equals wptr[ADDR_WIDTH-1:0].
- rd_addr  output  ADDR_WIDTH  equals rptr[ADDR_WIDTH-1:0].
- mem_we  output  1  combinational: wr_en & ~fifo_full.
- mem_re  output  1  combinational: rd_en & ~fifo_empty.
- rd_valid  output  1  registered: mem_re delayed by one cycle (marks the cycle the memory read data is valid).
- fifo_count  output  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH, registered.
- almost_full  output  1  registered threshold flag.
- almost_empty  output  1  registered threshold flag.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wptr=0, rptr=0, fifo_count=0, rd_valid=0, overflow=0, underflow=0, almost_full=0, almost_empty=1.
  - Reset dominates every other input; reset mid-transfer discards all contents.
  - mem_we/mem_re stay combinational; with pointers at 0 the status block reports empty, so mem_re=0.
- Write accept = mem_we. On accept: wptr <= wptr+1 (modulo 2^(ADDR_WIDTH+1), natural wrap; the MSB toggles each pass through the memory).
- Read accept = mem_re. On accept: rptr <= rptr+1, same wrap rule.
- Gating uses the flags of the current (pre-edge) pointers only. No same-cycle bypass:
  - Full and wr_en & rd_en: read accepted, write rejected, overflow sets.
  - Empty and wr_en & rd_en: write accepted, read rejected, underflow sets.
  - Neither full nor empty with both requests: both accepted, count unchanged.
- fifo_count next = count + we - re, computed in ADDR_WIDTH+1 bits; it never exceeds 2^ADDR_WIDTH and never goes below 0.
  - Invariant: fifo_count == wptr - rptr (mod 2^(ADDR_WIDTH+1)).
- almost_full / almost_empty are registered from the next-state count, so they are coherent with fifo_count in the same cycle.
- overflow sets on wr_en & fifo_full; underflow sets on rd_en & fifo_empty.
  - clr_flags clears both. Set has priority over clr_flags in the same cycle.
  - Flags hold otherwise.
- rd_valid <= mem_re each cycle (1-cycle read latency); it is cleared by reset.
- No state machine beyond the pointer/count registers; throughput is one write and one read per cycle.

Test Plan:
- Reset then idle 3 cycles -> wptr=rptr=0, fifo_count=0, almost_empty=1, almost_full=0, mem_re=0, flags 0.
- ADDR_WIDTH=3: 8 writes -> wptr=4'b1000, fifo_count=8, fifo_full=1 from the status block, almost_full=1; 9th write -> mem_we=0, wptr unchanged, overflow=1.
- From full, wr_en=rd_en=1 for 1 cycle -> rptr=1, wptr=8, fifo_count=7, overflow=1; next cycle rd_valid=1.
- Empty, wr_en=rd_en=1 -> wptr=1, rptr=0, fifo_count=1, underflow=1; then clr_flags=1 with idle requests -> underflow=0.
- Pointer wrap: 20 paired write/read cycles interleaved to keep count at 2 -> wptr wraps 15->0, fifo_count stays 2, mem_we=mem_re=1 throughout.
- rst asserted with fifo_count=5 while wr_en=1 -> next cycle all pointers/count 0, almost_empty=1, no write accepted in the reset cycle.
